// File: rtl/instr_fetch.sv
// Instruction fetch unit: paced requests to a fixed-latency memory, 2-entry in-order buffer, redirects.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign_o flag that halts fetch after a misaligned redirect.
module instr_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_o,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic                   imem_rvalid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   input  logic                   PCSrc_i,
   input  logic [ADDR_WIDTH-1:0]  PCTarget_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   output logic [1:0]             fsm_state
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                   misalign_o
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_next;
   logic [ADDR_WIDTH-1:0]   req_pc;
   logic [ADDR_WIDTH-1:0]   target;
   logic                    outstanding;
   logic                    misalign;
   logic                    redirect;
   logic                    req;
   logic                    push;
   logic                    pop;
   logic                    have_data;
   logic                    wr_ptr;
   logic                    head;
   logic [1:0]              count;
   logic [ADDR_WIDTH-1:0]   buf_pc    [2];
   logic [INSTR_WIDTH-1:0]  buf_instr [2];

`ifdef FETCH_ALIGN_CHECK_EN
   assign target = PCTarget_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign <= 1'b0;
      end else if (redirect) begin
         misalign <= (target[1:0] != 2'b00);
      end
   end

   assign misalign_o = misalign & ~rst;
`else
   assign target   = PCTarget_i & ~ADDR_WIDTH'(3);
   assign misalign = 1'b0;
`endif

   // Decode handshake: an entry transfers on a cycle where instr_valid_o and instr_ready_i
   // are both high; instr_o/pc_o are held until then and valid never drops without a transfer
   // except on redirect or reset.
   assign have_data = (count != 2'd0);
   assign pop       = have_data & instr_ready_i & ~rst;
   assign wr_ptr    = head ^ count[0];

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      redirect      = 1'b0;
      req           = 1'b0;
      case (state)
         BOOT: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (PCSrc_i) begin
               redirect      = 1'b1;
               fetch_pc_next = target;
               state_next    = outstanding ? DRAIN : FETCH;
            end else if (!misalign &&
                         ({1'b0, count} + {2'b00, outstanding}) < (3'd2 + {2'b00, pop})) begin
               // Slots already promised (buffered plus in flight) must stay within two.
               req           = 1'b1;
               fetch_pc_next = fetch_pc + PC_STEP;
            end
         end
         DRAIN: begin
            state_next = FETCH;
            if (PCSrc_i) begin
               redirect      = 1'b1;
               fetch_pc_next = target;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // Responses are kept only for a live request seen in FETCH without a redirect.
   assign push = imem_rvalid_i & outstanding & (state == FETCH) & ~redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         outstanding <= 1'b0;
         req_pc      <= '0;
      end else begin
         state       <= state_next;
         fetch_pc    <= fetch_pc_next;
         outstanding <= req;
         if (req) begin
            req_pc <= fetch_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         head  <= 1'b0;
      end else if (redirect) begin
         count <= 2'd0;
         head  <= 1'b0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         head  <= head ^ pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         buf_pc[wr_ptr]    <= req_pc;
         buf_instr[wr_ptr] <= imem_rdata_i;
      end
   end

   assign imem_req_o    = req & ~rst;
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = have_data & ~rst;
   assign instr_o       = instr_valid_o ? buf_instr[head] : '0;
   assign pc_o          = instr_valid_o ? buf_pc[head] : '0;
   assign fsm_state     = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset timing, streaming, backpressure, redirects,
// PC wrap (second instance with RESET_PC at the top of memory), and misaligned targets.
module tb_instr_fetch;

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCSrc_i;
   logic [31:0] PCTarget_i;
   logic        instr_ready_i;
   logic        inject_rvalid;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic        mem_rvalid;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic [1:0]  fsm_state;

   logic        req2;
   logic [31:0] addr2;
   logic        rvalid2;
   logic [31:0] rdata2;
   logic [31:0] instr2;
   logic [31:0] pc2;
   logic        valid2;
   logic [1:0]  state2;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_o;
   logic        misalign2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .PCSrc_i(PCSrc_i), .PCTarget_i(PCTarget_i),
      .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i), .fsm_state(fsm_state)
`ifdef FETCH_ALIGN_CHECK_EN
      , .misalign_o(misalign_o)
`endif
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req_o(req2), .imem_addr_o(addr2),
      .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
      .PCSrc_i(PCSrc_i), .PCTarget_i(PCTarget_i),
      .instr_o(instr2), .pc_o(pc2), .instr_valid_o(valid2),
      .instr_ready_i(instr_ready_i), .fsm_state(state2)
`ifdef FETCH_ALIGN_CHECK_EN
      , .misalign_o(misalign2)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory model: every request answered exactly one cycle later.
   always @(posedge clk) begin
      mem_rvalid   <= imem_req_o;
      imem_rdata_i <= mem_word(imem_addr_o);
      rvalid2      <= req2;
      rdata2       <= mem_word(addr2);
   end

   assign imem_rvalid_i = mem_rvalid | inject_rvalid;

   task automatic drive(input logic src, input logic [31:0] tgt, input logic rdy);
      @(negedge clk);
      PCSrc_i       = src;
      PCTarget_i    = tgt;
      instr_ready_i = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req_o); end
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
      n_checks++; if (instr_o !== 32'h0 || pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: instr %h pc %h want 0 0", instr_o, pc_o); end
      n_checks++; if (fsm_state !== S_BOOT) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_BOOT); end
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (fsm_state !== S_BOOT || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL boot_cycle0: state %0d req %0b want 0 0", fsm_state, imem_req_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL first_req: req %0b addr %h want 1 00000000", imem_req_o, imem_addr_o); end
      n_checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: req %0b addr %h want 1 fffffffc", req2, addr2); end
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL early_valid_c1: got %0b want 0", instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL second_req: req %0b addr %h want 1 00000004", imem_req_o, imem_addr_o); end
      n_checks++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_second: req %0b addr %h want 1 00000000", req2, addr2); end
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL early_valid_c2: got %0b want 0", instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hC0DE_0000) begin n_fail++; $display("FAIL first_instr: valid %0b pc %h instr %h want 1 00000000 c0de0000", instr_valid_o, pc_o, instr_o); end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 32'h0, 1'b1);
         exp_pc = 32'(4 * k);
         n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stream_%0d: valid %0b pc %h instr %h want pc %h", k, instr_valid_o, pc_o, instr_o, exp_pc); end
         n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc + 32'h8) begin n_fail++; $display("FAIL stream_req_%0d: req %0b addr %h want 1 %h", k, imem_req_o, imem_addr_o, exp_pc + 32'h8); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 1'b0);
         n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h10 || instr_o !== 32'hC0DE_0010) begin n_fail++; $display("FAIL hold_%0d: valid %0b pc %h instr %h want 1 00000010 c0de0010", i, instr_valid_o, pc_o, instr_o); end
         n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req_%0d: got %0b want 0", i, imem_req_o); end
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 32'h0, 1'b1);
         exp_pc = 32'h10 + 32'(4 * k);
         n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin n_fail++; $display("FAIL resume_%0d: valid %0b pc %h instr %h want pc %h", k, instr_valid_o, pc_o, instr_o, exp_pc); end
         if (k == 0) begin
            n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin n_fail++; $display("FAIL resume_req: req %0b addr %h want 1 00000018", imem_req_o, imem_addr_o); end
         end
      end
   endtask

   task automatic test_redirect_outstanding();
      drive(1'b1, 32'h100, 1'b1);
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %0b want 0", imem_req_o); end
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h20) begin n_fail++; $display("FAIL redir_pop: valid %0b pc %h want 1 00000020", instr_valid_o, pc_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (fsm_state !== S_DRAIN || instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL drain: state %0d valid %0b req %0b want 2 0 0", fsm_state, instr_valid_o, imem_req_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (fsm_state !== S_FETCH || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_drain: state %0d req %0b addr %h valid %0b want 1 1 00000100 0", fsm_state, imem_req_o, imem_addr_o, instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_addr_o !== 32'h104 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_drain2: addr %h valid %0b want 00000104 0", imem_addr_o, instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'hC0DE_0100) begin n_fail++; $display("FAIL target_instr: valid %0b pc %h instr %h want 1 00000100 c0de0100", instr_valid_o, pc_o, instr_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h104) begin n_fail++; $display("FAIL target_next: valid %0b pc %h want 1 00000104", instr_valid_o, pc_o); end
   endtask

   task automatic test_redirect_idle();
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      n_checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'h108) begin n_fail++; $display("FAIL idle_full: req %0b pc %h want 0 00000108", imem_req_o, pc_o); end
      drive(1'b1, 32'h200, 1'b0);
      n_checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || pc_o !== 32'h108) begin n_fail++; $display("FAIL idle_redir: req %0b valid %0b pc %h want 0 1 00000108", imem_req_o, instr_valid_o, pc_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (fsm_state !== S_FETCH || instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL idle_after: state %0d valid %0b req %0b addr %h want 1 0 1 00000200", fsm_state, instr_valid_o, imem_req_o, imem_addr_o); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'hC0DE_0200) begin n_fail++; $display("FAIL idle_target: valid %0b pc %h instr %h want 1 00000200 c0de0200", instr_valid_o, pc_o, instr_o); end
   endtask

   task automatic test_misalign();
      drive(1'b1, 32'h102, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL misalign_set: flag %0b req %0b want 1 0", misalign_o, imem_req_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || fsm_state !== S_FETCH) begin n_fail++; $display("FAIL misalign_hold: flag %0b req %0b state %0d want 1 0 1", misalign_o, imem_req_o, fsm_state); end
      drive(1'b1, 32'h200, 1'b1);
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL misalign_redir_req: got %0b want 0", imem_req_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL misalign_clear: flag %0b req %0b addr %h want 0 1 00000200", misalign_o, imem_req_o, imem_addr_o); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h200) begin n_fail++; $display("FAIL misalign_resume: valid %0b pc %h want 1 00000200", instr_valid_o, pc_o); end
`else
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (fsm_state !== S_DRAIN || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL align_drain: state %0d valid %0b want 2 0", fsm_state, instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL align_forced: req %0b addr %h want 1 00000100", imem_req_o, imem_addr_o); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'hC0DE_0100) begin n_fail++; $display("FAIL align_instr: valid %0b pc %h instr %h want 1 00000100 c0de0100", instr_valid_o, pc_o, instr_o); end
`endif
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outputs: req %0b valid %0b want 0 0", imem_req_o, instr_valid_o); end
      @(negedge clk);
      rst = 1'b0;
      inject_rvalid = 1'b1;
      #1;
      n_checks++; if (fsm_state !== S_BOOT || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_boot: state %0d valid %0b want 0 0", fsm_state, instr_valid_o); end
      @(negedge clk);
      inject_rvalid = 1'b0;
      #1;
      n_checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ignore: valid %0b req %0b addr %h want 0 1 00000000", instr_valid_o, imem_req_o, imem_addr_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_c2: valid %0b want 0", instr_valid_o); end
      drive(1'b0, 32'h0, 1'b1);
      n_checks++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hC0DE_0000) begin n_fail++; $display("FAIL mid_rst_first: valid %0b pc %h instr %h want 1 00000000 c0de0000", instr_valid_o, pc_o, instr_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      PCSrc_i       = 1'b0;
      PCTarget_i    = 32'h0;
      instr_ready_i = 1'b1;
      inject_rvalid = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_outstanding();
      test_redirect_idle();
      test_misalign();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
